mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one mem_system_hier instance between the fetch (instruction-read) and memory
//  (data read/write/dump) stages of the pipeline.
//  - Data side has fixed priority; a starvation counter guarantees forward progress for fetch.
//  - Holds the grant for a whole transaction (request -> Done).
//  - Returns Done, data and stall per requester.
//  - Watchdog flags a hung memory.
// PARAMETERS
//  STARVE_LIMIT  4     consecutive D grants while I waits before I is forced next (1..15)
//  TIMEOUT       255   max cycles in a BUSY state before watchdog error (1..255)
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous, active-low reset (0 = reset)
//  i_rd        in   1   fetch read request, held until i_done
//  i_addr      in   16  fetch address, stable while i_rd
//  i_data      out  16  instruction, valid when i_done
//  i_done      out  1   one-cycle completion pulse to fetch
//  i_stall     out  1   fetch request pending, not completing this cycle
//  d_rd        in   1   data read request, held until d_done
//  d_wr        in   1   data write request, held until d_done (d_rd & d_wr = illegal)
//  d_dump      in   1   createdump, forwarded with data transactions
//  d_addr      in   16  data address
//  d_wdata     in   16  write data
//  d_data      out  16  read data, valid when d_done
//  d_done      out  1   one-cycle completion pulse to memory stage
//  d_stall     out  1   data request pending, not completing this cycle
//  mem_addr    out  16  to mem_system_hier Addr
//  mem_datain  out  16  to DataIn
//  mem_rd      out  1   to Rd
//  mem_wr      out  1   to Wr
//  mem_dump    out  1   to createdump
//  mem_dataout in   16  from DataOut
//  mem_done    in   1   from Done
//  mem_err     in   1   from err
//  err         out  1   mem_err during BUSY | d_rd&d_wr | sticky watchdog
// BEHAVIOUR
//  - Reset (rst=0, immediate): state=IDLE, starve_cnt=0, wd_cnt=0, wd_err=0.
//    All outputs 0; mem_rd/mem_wr drop asynchronously.
//  - States:
//    - IDLE: mem_rd=mem_wr=0; mem_addr/mem_datain=0.
//      - Request present -> registered grant.
//      - Next = D_BUSY if (d_rd|d_wr) & ~(i_rd & starve_cnt==STARVE_LIMIT).
//      - Else I_BUSY if i_rd.
//      - Else stay IDLE.
//    - I_BUSY: mem_addr=i_addr, mem_rd=1, mem_wr=0, mem_dump=0.
//      - On mem_done: i_done=1, i_data=mem_dataout, next IDLE.
//    - D_BUSY: mem_addr=d_addr, mem_datain=d_wdata, mem_rd=d_rd, mem_wr=d_wr, mem_dump=d_dump.
//      - On mem_done: d_done=1, d_data=mem_dataout, next IDLE.
//  - Latency: request in IDLE at cycle N -> mem_rd/wr high from N+1.
//    Done is combinational from mem_done; at least one IDLE cycle between transactions.
//  - i_data/d_data are 0 whenever the matching done is 0.
//  - Stall: x_stall = x_req & ~(state==X_BUSY & mem_done); combinational.
//  - starve_cnt, updated on IDLE->D_BUSY:
//    - +1 (saturating at STARVE_LIMIT) if i_rd.
//    - Cleared on IDLE->I_BUSY.
//    - Cleared on IDLE->D_BUSY when i_rd=0.
//  - Abandoned request (requester drops rd/wr mid-BUSY, e.g. fetch flush):
//    - Transaction still completes with mem signals held from the latched granted side (rd/wr,
//      addr, data latched at grant).
//    - Done pulse is suppressed if the request is low in the completing cycle.
//  - Watchdog:
//    - wd_cnt clears on entry to BUSY and increments each BUSY cycle without mem_done.
//    - wd_cnt==TIMEOUT -> wd_err=1 (sticky until reset) and state forced to IDLE, no done.
//  - Simultaneous mem_done and new request in the same cycle: the request is arbitrated in the
//    following IDLE cycle.
// TESTING
//  1 i_rd=1, i_addr=0x0010; mem_done after 3 BUSY cycles, mem_dataout=0x1234
//    -> mem_rd high cycles 1-3; i_done pulse cycle 3 with i_data=0x1234; i_stall high cycles 0-2.
//  2 i_rd & d_wr both asserted in IDLE (d_addr=0x0200, d_wdata=0xBEEF)
//    -> D_BUSY first with mem_wr=1, mem_datain=0xBEEF; I served next; starve_cnt=1.
//  3 d_rd held continuously and i_rd held, STARVE_LIMIT=4
//    -> grant order D,D,D,D,I,D...; i_done after the 4th d_done.
//  4 i_rd dropped during I_BUSY (flush)
//    -> mem_rd stays high until mem_done; i_done stays 0; next transaction is accepted normally.
//  5 mem_done never arrives, TIMEOUT=8
//    -> err=1 after 8 BUSY cycles; state returns to IDLE; err stays 1 until rst=0.
//  6 rst=0 asserted mid D_BUSY
//    -> mem_wr=0 same cycle; all outputs 0; after release, first request is granted normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-side, data-side and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_arbiter_if;
  logic        i_rd;
  logic [15:0] i_addr;
  logic [15:0] i_data;
  logic        i_done;
  logic        i_stall;
  logic        d_rd;
  logic        d_wr;
  logic        d_dump;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_data;
  logic        d_done;
  logic        d_stall;
  logic [15:0] mem_addr;
  logic [15:0] mem_datain;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_dump;
  logic [15:0] mem_dataout;
  logic        mem_done;
  logic        mem_err;
  logic        err;

  modport slave (
    input  i_rd, i_addr, d_rd, d_wr, d_dump, d_addr, d_wdata,
           mem_dataout, mem_done, mem_err,
    output i_data, i_done, i_stall, d_data, d_done, d_stall,
           mem_addr, mem_datain, mem_rd, mem_wr, mem_dump, err
  );

  modport master (
    output i_rd, i_addr, d_rd, d_wr, d_dump, d_addr, d_wdata,
           mem_dataout, mem_done, mem_err,
    input  i_data, i_done, i_stall, d_data, d_done, d_stall,
           mem_addr, mem_datain, mem_rd, mem_wr, mem_dump, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory between fetch and data requesters: data has priority, a
// starvation counter forces fetch through, and a watchdog flags a hung memory.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);

  state_t      state;
  logic [3:0]  starve_cnt;
  logic [7:0]  wd_cnt;
  logic        wd_err;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_datain_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic        mem_dump_q;

  logic d_req;
  logic grant_d;
  logic grant_i;
  logic i_complete;
  logic d_complete;
  logic busy;

  always_comb begin
    d_req      = bus.d_rd | bus.d_wr;
    grant_d    = d_req && !(bus.i_rd && (starve_cnt == STARVE_MAX));
    grant_i    = !grant_d && bus.i_rd;
    i_complete = (state == I_BUSY) && bus.mem_done;
    d_complete = (state == D_BUSY) && bus.mem_done;
    busy       = (state != IDLE);
  end

  // Memory-side controls are latched at grant so an abandoned request still
  // drives a coherent transaction to completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      wd_cnt       <= '0;
      wd_err       <= 1'b0;
      mem_addr_q   <= '0;
      mem_datain_q <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_dump_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (grant_d) begin
            state        <= D_BUSY;
            mem_addr_q   <= bus.d_addr;
            mem_datain_q <= bus.d_wdata;
            mem_rd_q     <= bus.d_rd;
            mem_wr_q     <= bus.d_wr;
            mem_dump_q   <= bus.d_dump;
            if (!bus.i_rd) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end else if (grant_i) begin
            state        <= I_BUSY;
            mem_addr_q   <= bus.i_addr;
            mem_datain_q <= '0;
            mem_rd_q     <= 1'b1;
            mem_wr_q     <= 1'b0;
            mem_dump_q   <= 1'b0;
            starve_cnt   <= '0;
          end
        end
        I_BUSY, D_BUSY: begin
          if (bus.mem_done || (wd_cnt == WD_LAST)) begin
            state        <= IDLE;
            mem_addr_q   <= '0;
            mem_datain_q <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_dump_q   <= 1'b0;
            if (!bus.mem_done) begin
              wd_err <= 1'b1;
            end
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_datain = mem_datain_q;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_dump   = mem_dump_q;

  assign bus.i_done = i_complete & bus.i_rd;
  assign bus.d_done = d_complete & d_req;
  assign bus.i_data = bus.i_done ? bus.mem_dataout : '0;
  assign bus.d_data = bus.d_done ? bus.mem_dataout : '0;

  // Request-derived outputs are masked by rst so every output reads 0 in reset.
  assign bus.i_stall = rst & bus.i_rd & ~i_complete;
  assign bus.d_stall = rst & d_req & ~d_complete;
  assign bus.err     = rst & ((bus.mem_err & busy) | (bus.d_rd & bus.d_wr) | wd_err);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized fetch/data traffic against a transaction-level memory reference,
// plus directed latency, watchdog and reset-during-transaction checks.
module tb_mem_arbiter;

  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .STARVE_LIMIT(4),
    .TIMEOUT     (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [15:0] tb_mem  [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] exp_i [$];
  logic [15:0] exp_d [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [15:0] init_val(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] tb_mem_rd(input logic [15:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : init_val(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Memory model: random latency, junk on DataOut except in the Done cycle.
  int forced_lat = -1;
  bit mem_hang   = 1'b0;
  bit mem_active = 1'b0;
  int mem_lat    = 0;

  initial begin
    bus.mem_done    = 1'b0;
    bus.mem_err     = 1'b0;
    bus.mem_dataout = '0;
  end

  always begin
    @(posedge clk);
    #1;
    bus.mem_done    = 1'b0;
    bus.mem_dataout = 16'($urandom);
    if (bus.mem_rd || bus.mem_wr) begin
      if (!mem_active) begin
        mem_active = 1'b1;
        mem_lat    = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 3));
      end
      if (!mem_hang) begin
        if (mem_lat == 0) begin
          bus.mem_done = 1'b1;
          mem_active   = 1'b0;
          if (bus.mem_wr) begin
            bus.mem_dataout        = '0;
            tb_mem[bus.mem_addr]   = bus.mem_datain;
          end else begin
            bus.mem_dataout = tb_mem_rd(bus.mem_addr);
          end
        end else begin
          mem_lat--;
        end
      end
    end else begin
      mem_active = 1'b0;
    end
  end

  // Request levels as seen by the arbiter at each rising edge.
  logic samp_i = 1'b0;
  logic samp_d = 1'b0;
  always @(posedge clk) begin
    samp_i <= bus.i_rd;
    samp_d <= bus.d_rd | bus.d_wr;
  end

  // Monitor: grant-order rule model plus scoreboard pops on each Done.
  bit          sb_en    = 1'b0;
  bit          prev_act = 1'b0;
  bit          cur_d    = 1'b0;
  int unsigned run      = 0;
  logic        act;
  logic        exp_gd;
  logic        exp_idn;
  logic        exp_ddn;
  logic [15:0] e;

  always @(negedge clk) begin
    if (sb_en) begin
      act = bus.mem_rd | bus.mem_wr;
      if (act && !prev_act) begin
        exp_gd = samp_d && !(samp_i && run == LIMIT);
        cur_d  = (bus.mem_addr >= 16'h1000);
        chk("grant_side_is_d", 32'(cur_d), 32'(exp_gd));
        if (exp_gd) run = samp_i ? ((run < LIMIT) ? run + 1 : run) : 0;
        else        run = 0;
      end
      exp_idn = act && !cur_d && bus.mem_done && bus.i_rd;
      exp_ddn = act &&  cur_d && bus.mem_done && (bus.d_rd || bus.d_wr);
      chk("i_done", 32'(bus.i_done), 32'(exp_idn));
      chk("d_done", 32'(bus.d_done), 32'(exp_ddn));
      if (bus.i_done) begin
        if (exp_i.size() == 0) fail_now("i_done_unexpected");
        else begin
          e = exp_i.pop_front();
          chk("i_data", 32'(bus.i_data), 32'(e));
        end
      end else chk("i_data_zero", 32'(bus.i_data), 32'd0);
      if (bus.d_done) begin
        if (exp_d.size() == 0) fail_now("d_done_unexpected");
        else begin
          e = exp_d.pop_front();
          chk("d_data", 32'(bus.d_data), 32'(e));
        end
      end else chk("d_data_zero", 32'(bus.d_data), 32'd0);
      chk("i_stall", 32'(bus.i_stall), 32'(bus.i_rd && !(act && !cur_d && bus.mem_done)));
      chk("d_stall", 32'(bus.d_stall), 32'((bus.d_rd || bus.d_wr) && !(act && cur_d && bus.mem_done)));
      chk("err_quiet", 32'(bus.err), 32'd0);
      prev_act = act;
    end
  end

  task automatic wait_idle();
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((bus.mem_rd || bus.mem_wr) && w < 50);
    if (w >= 50) fail_now("wait_idle_timeout");
  endtask

  task automatic run_i(input int n, input bit allow_flush);
    int unsigned gap;
    int          waited;
    bit          fin;
    logic [15:0] a;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk); #1;
        bus.i_rd = 1'b0;
      end
      @(posedge clk); #1;
      a = 16'($urandom_range(0, 255));
      bus.i_addr = a;
      bus.i_rd   = 1'b1;
      exp_i.push_back(ref_rd(a));
      waited = 0;
      fin    = 1'b0;
      while (!fin) begin
        @(negedge clk);
        if (bus.i_done) fin = 1'b1;
        else if (waited >= 200) begin
          fail_now("i_request_timeout");
          fin = 1'b1;
        end else begin
          waited++;
          if (allow_flush && $urandom_range(0, 11) == 0) begin
            @(posedge clk); #1;
            bus.i_rd = 1'b0;
            void'(exp_i.pop_back());
            wait_idle();
            fin = 1'b1;
          end
        end
      end
    end
    @(posedge clk); #1;
    bus.i_rd = 1'b0;
  endtask

  task automatic run_d(input int n);
    int unsigned gap;
    int          waited;
    bit          is_rd;
    logic [15:0] a;
    logic [15:0] wd;
    for (int k = 0; k < n; k++) begin
      gap = ($urandom_range(0, 3) == 0) ? 1 : 0;
      repeat (gap) begin
        @(posedge clk); #1;
        bus.d_rd = 1'b0;
        bus.d_wr = 1'b0;
      end
      @(posedge clk); #1;
      is_rd       = 1'($urandom_range(0, 1));
      a           = 16'h1000 + 16'($urandom_range(0, 15));
      wd          = 16'($urandom);
      bus.d_addr  = a;
      bus.d_wdata = wd;
      bus.d_dump  = 1'($urandom_range(0, 1));
      bus.d_rd    = is_rd;
      bus.d_wr    = !is_rd;
      if (is_rd) exp_d.push_back(ref_rd(a));
      else begin
        ref_mem[a] = wd;
        exp_d.push_back(16'h0000);
      end
      waited = 0;
      while (waited >= 0) begin
        @(negedge clk);
        if (bus.d_done) waited = -1;
        else if (waited >= 200) begin
          fail_now("d_request_timeout");
          waited = -1;
        end else waited++;
      end
    end
    @(posedge clk); #1;
    bus.d_rd = 1'b0;
    bus.d_wr = 1'b0;
  endtask

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL global_timeout: simulation did not finish within cycle budget");
    $fatal(1, "global timeout");
  end

  initial begin
    bus.i_rd = 1'b0;  bus.i_addr = '0;
    bus.d_rd = 1'b0;  bus.d_wr = 1'b0;  bus.d_dump = 1'b0;
    bus.d_addr = '0;  bus.d_wdata = '0;
    tb_mem[16'h0010]  = 16'h1234;
    ref_mem[16'h0010] = 16'h1234;

    // Reset with live requests: every output must still read 0.
    bus.i_rd = 1'b1;
    bus.d_rd = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 32'({bus.mem_rd, bus.mem_wr, bus.mem_dump, bus.i_done, bus.d_done,
                          bus.i_stall, bus.d_stall, bus.err}), 32'd0);
    chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("reset_mem_datain", 32'(bus.mem_datain), 32'd0);
    bus.i_rd = 1'b0;
    bus.d_rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Single fetch, three BUSY cycles.
    @(posedge clk); #1;
    sb_en      = 1'b1;
    forced_lat = 2;
    bus.i_addr = 16'h0010;
    bus.i_rd   = 1'b1;
    exp_i.push_back(16'h1234);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t1_mem_rd",  32'(bus.mem_rd),  32'(c >= 1));
      chk("t1_i_stall", 32'(bus.i_stall), 32'(c <= 2));
      chk("t1_i_done",  32'(bus.i_done),  32'(c == 3));
      if (c == 3) chk("t1_i_data", 32'(bus.i_data), 32'h1234);
    end
    @(posedge clk); #1;
    bus.i_rd   = 1'b0;
    forced_lat = -1;

    fork
      run_i(60, 1'b1);
      run_d(120);
    join
    repeat (10) @(negedge clk);
    chk("i_queue_drained", 32'(exp_i.size()), 32'd0);
    chk("d_queue_drained", 32'(exp_d.size()), 32'd0);
    sb_en = 1'b0;

    // Hung memory: watchdog after 8 BUSY cycles, sticky error.
    mem_hang = 1'b1;
    @(posedge clk); #1;
    bus.i_addr = 16'h0020;
    bus.i_rd   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t5_err",    32'(bus.err),    32'(c == 9));
      chk("t5_mem_rd", 32'(bus.mem_rd), 32'(c >= 1 && c <= 8));
    end
    bus.i_rd = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_err_sticky", 32'(bus.err), 32'd1);
      chk("t5_back_idle",  32'(bus.mem_rd), 32'd0);
    end

    // Reset asserted in the middle of a data write.
    bus.d_addr  = 16'h1004;
    bus.d_wdata = 16'hBEEF;
    bus.d_rd    = 1'b0;
    bus.d_wr    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_mem_wr",     32'(bus.mem_wr),     32'd1);
    chk("t6_mem_datain", 32'(bus.mem_datain), 32'hBEEF);
    #2 rst = 1'b0;
    #1;
    chk("t6_mem_wr_drop", 32'(bus.mem_wr), 32'd0);
    chk("t6_ctrl_zero", 32'({bus.mem_rd, bus.mem_wr, bus.mem_dump, bus.i_done, bus.d_done,
                            bus.i_stall, bus.d_stall, bus.err}), 32'd0);
    chk("t6_addr_zero", 32'(bus.mem_addr), 32'd0);
    bus.d_wr = 1'b0;
    mem_hang = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    @(posedge clk); #1;
    prev_act = 1'b0;
    run      = 0;
    sb_en    = 1'b1;
    fork
      run_i(4, 1'b0);
      run_d(4);
    join
    repeat (6) @(negedge clk);
    chk("post_rst_i_drained", 32'(exp_i.size()), 32'd0);
    chk("post_rst_d_drained", 32'(exp_d.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
